// File: rtl/latch_stage_skid.sv
// Pipeline-stage register for the register-writeback bundle, with a valid/ready
// handshake and a two-entry skid buffer so the stage runs at full rate under back-pressure.
module latch_stage_skid #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 5,
   parameter int SUPPRESS_R0 = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_write_enable,
   input  logic [ADDR_WIDTH-1:0] in_write_address,
   input  logic [DATA_WIDTH-1:0] in_write_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_write_enable,
   output logic [ADDR_WIDTH-1:0] out_write_address,
   output logic [DATA_WIDTH-1:0] out_write_data,
   output logic [1:0]            occupancy
);

   // state | meaning
   // EMPTY | no bundle held; outputs show the last bundle with enable forced low
   // ONE   | main entry holds the bundle being presented downstream
   // FULL  | main presented, skid holds the next bundle; upstream is stalled
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic                  main_we, skid_we;
   logic [ADDR_WIDTH-1:0] main_addr, skid_addr;
   logic [DATA_WIDTH-1:0] main_data, skid_data;

   logic in_fire, out_fire, cap_we, addr_zero;
   logic load_main_in, load_main_skid, load_skid, clear_we;

   assign in_ready  = (state != FULL);
   assign out_valid = (state != EMPTY);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   // Writes to $zero are turned into no-ops at capture; address and data are kept intact.
   assign addr_zero = (in_write_address == '0);
   assign cap_we    = in_write_enable & ~((SUPPRESS_R0 != 0) & addr_zero);

   always_comb begin
      state_nxt      = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      clear_we       = 1'b0;
      if (flush) begin
         state_nxt = EMPTY;
         clear_we  = 1'b1;
      end else begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  state_nxt    = ONE;
                  load_main_in = 1'b1;
               end
            end
            ONE: begin
               if (in_fire && !out_fire) begin
                  state_nxt = FULL;
                  load_skid = 1'b1;
               end else if (in_fire && out_fire) begin
                  load_main_in = 1'b1;
               end else if (out_fire) begin
                  state_nxt = EMPTY;
               end
            end
            FULL: begin
               if (out_fire) begin
                  state_nxt      = ONE;
                  load_main_skid = 1'b1;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= EMPTY;
         main_we   <= 1'b0;
         main_addr <= '0;
         main_data <= '0;
         skid_we   <= 1'b0;
         skid_addr <= '0;
         skid_data <= '0;
      end else begin
         state <= state_nxt;
         if (clear_we) begin
            main_we <= 1'b0;
            skid_we <= 1'b0;
         end else begin
            if (load_main_in) begin
               main_we   <= cap_we;
               main_addr <= in_write_address;
               main_data <= in_write_data;
            end else if (load_main_skid) begin
               main_we   <= skid_we;
               main_addr <= skid_addr;
               main_data <= skid_data;
            end
            if (load_skid) begin
               skid_we   <= cap_we;
               skid_addr <= in_write_address;
               skid_data <= in_write_data;
            end
         end
      end
   end

   // Address and data stay visible when idle; only the enable is qualified by valid.
   assign out_write_enable  = main_we & out_valid;
   assign out_write_address = main_addr;
   assign out_write_data    = main_data;
   assign occupancy         = state;

endmodule

// File: tb/tb_latch_stage_skid.sv
// Scoreboard bench for latch_stage_skid: two instances (with and without $zero
// suppression) share stimulus; a queue model predicts every output each cycle.
module tb_latch_stage_skid;

   logic        clock = 1'b0;
   logic        reset, flush, in_valid, in_write_enable, out_ready;
   logic [4:0]  in_write_address;
   logic [31:0] in_write_data;

   logic        in_ready, out_valid, out_write_enable;
   logic [4:0]  out_write_address;
   logic [31:0] out_write_data;
   logic [1:0]  occupancy;

   logic        z_in_ready, z_out_valid, z_out_write_enable;
   logic [4:0]  z_out_write_address;
   logic [31:0] z_out_write_data;
   logic [1:0]  z_occupancy;

   always #5 clock = ~clock;

   latch_stage_skid #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .SUPPRESS_R0(1)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_write_enable(in_write_enable), .in_write_address(in_write_address),
      .in_write_data(in_write_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_write_enable(out_write_enable), .out_write_address(out_write_address),
      .out_write_data(out_write_data), .occupancy(occupancy)
   );

   latch_stage_skid #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .SUPPRESS_R0(0)) dut_nosup (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(z_in_ready),
      .in_write_enable(in_write_enable), .in_write_address(in_write_address),
      .in_write_data(in_write_data),
      .out_valid(z_out_valid), .out_ready(out_ready),
      .out_write_enable(z_out_write_enable), .out_write_address(z_out_write_address),
      .out_write_data(z_out_write_data), .occupancy(z_occupancy)
   );

   typedef struct {
      logic        we_s;
      logic        we_n;
      logic [4:0]  addr;
      logic [31:0] data;
   } bundle_t;

   bundle_t     q[$];
   logic [4:0]  last_addr;
   logic [31:0] last_data;
   bit          model_ok = 1'b0;
   int          total = 0;
   int          bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock: compare current outputs against the model, advance the model, clock.
   task automatic step();
      int      sz;
      bit      in_fire, out_fire;
      bundle_t b;
      #1;
      sz = q.size();
      if (model_ok) begin
         chk("occupancy", 64'(occupancy), 64'(sz));
         chk("occupancy_nosup", 64'(z_occupancy), 64'(sz));
         chk("in_ready", 64'(in_ready), 64'(sz != 2));
         chk("out_valid", 64'(out_valid), 64'(sz != 0));
         chk("out_valid_nosup", 64'(z_out_valid), 64'(sz != 0));
         if (sz != 0) begin
            chk("out_we", 64'(out_write_enable), 64'(q[0].we_s));
            chk("out_we_nosup", 64'(z_out_write_enable), 64'(q[0].we_n));
            chk("out_addr", 64'(out_write_address), 64'(q[0].addr));
            chk("out_data", 64'(out_write_data), 64'(q[0].data));
         end else begin
            chk("idle_we", 64'(out_write_enable), 64'(0));
            chk("idle_we_nosup", 64'(z_out_write_enable), 64'(0));
            chk("idle_addr_hold", 64'(out_write_address), 64'(last_addr));
            chk("idle_data_hold", 64'(out_write_data), 64'(last_data));
         end
      end
      if (reset) begin
         q.delete();
         last_addr = '0;
         last_data = '0;
         model_ok  = 1'b1;
      end else if (model_ok) begin
         if (sz != 0) begin
            last_addr = q[0].addr;
            last_data = q[0].data;
         end
         in_fire  = in_valid && (sz != 2);
         out_fire = (sz != 0) && out_ready;
         if (out_fire) void'(q.pop_front());
         if (flush) q.delete();
         else if (in_fire) begin
            b.we_n = in_write_enable;
            b.we_s = in_write_enable && (in_write_address != 5'd0);
            b.addr = in_write_address;
            b.data = in_write_data;
            q.push_back(b);
         end
      end
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic drive(input logic v, input logic we, input logic [4:0] a,
                        input logic [31:0] d, input logic rdy);
      in_valid         = v;
      in_write_enable  = we;
      in_write_address = a;
      in_write_data    = d;
      out_ready        = rdy;
      step();
   endtask

   task automatic drain();
      out_ready = 1'b1;
      in_valid  = 1'b0;
      for (int i = 0; i < 20 && q.size() != 0; i++) step();
      chk("drain_empty", 64'(q.size()), 64'(0));
      step();
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0;
      in_valid = 1'b1; in_write_enable = 1'b1; in_write_address = 5'h1f;
      in_write_data = 32'hFFFF_FFFF; out_ready = 1'b1;
      @(negedge clock);
      repeat (3) step();
      chk("rst_addr_zero", 64'(out_write_address), 64'(0));
      chk("rst_data_zero", 64'(out_write_data), 64'(0));
      reset = 1'b0;
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);

      // streaming
      drive(1'b1, 1'b1, 5'd1, 32'hA, 1'b1);
      drive(1'b1, 1'b1, 5'd2, 32'hB, 1'b1);
      drive(1'b1, 1'b1, 5'd3, 32'hC, 1'b1);
      drain();

      // back-pressure
      drive(1'b1, 1'b1, 5'd4, 32'h11, 1'b0);
      drive(1'b1, 1'b1, 5'd5, 32'h22, 1'b0);
      drive(1'b1, 1'b1, 5'd6, 32'h33, 1'b0);
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
      drain();

      // $zero write
      drive(1'b1, 1'b1, 5'd0, 32'hDEAD, 1'b0);
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
      drain();

      // flush while FULL with an incoming bundle
      drive(1'b1, 1'b1, 5'd7, 32'h77, 1'b0);
      drive(1'b1, 1'b1, 5'd8, 32'h88, 1'b0);
      flush = 1'b1;
      drive(1'b1, 1'b1, 5'd9, 32'h99, 1'b0);
      flush = 1'b0;
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
      drain();

      // reset while FULL with out_ready toggling
      drive(1'b1, 1'b1, 5'd10, 32'h1010, 1'b0);
      drive(1'b1, 1'b1, 5'd11, 32'h1111, 1'b0);
      reset = 1'b1;
      drive(1'b1, 1'b1, 5'd12, 32'h1212, 1'b1);
      drive(1'b1, 1'b1, 5'd13, 32'h1313, 1'b0);
      chk("midrst_addr_zero", 64'(out_write_address), 64'(0));
      reset = 1'b0;
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
      drain();

      // random traffic
      for (int i = 0; i < 300; i++) begin
         flush = ($urandom_range(0, 19) == 0);
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 2) != 0));
      end
      flush = 1'b0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
